// File: rtl/rs232_ram_cmd_ctrl_if.sv
// ----------------------------------------------------------------------------
// rs232_ram_cmd_ctrl_if
//   Bundles the three handshake/bus groups around the command controller:
//     packet in  : pkt_valid, pkt_data[63:0], pkt_ready
//     RAM port   : ram_addr[6:0], ram_din[31:0], ram_en, ram_we, ram_dout[31:0]
//     packet out : tx_data[63:0], tx_start, tx_done
//   master : the controller (accepts packets, owns the RAM port, drives TX)
//   slave  : the surrounding RX block, RAM and transmitter
// ----------------------------------------------------------------------------
interface rs232_ram_cmd_ctrl_if;
    logic        pkt_valid;
    logic [63:0] pkt_data;
    logic        pkt_ready;

    logic [6:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_dout;

    logic [63:0] tx_data;
    logic        tx_start;
    logic        tx_done;

    modport master (
        input  pkt_valid, pkt_data, ram_dout, tx_done,
        output pkt_ready, ram_addr, ram_din, ram_en, ram_we, tx_data, tx_start
    );

    modport slave (
        output pkt_valid, pkt_data, ram_dout, tx_done,
        input  pkt_ready, ram_addr, ram_din, ram_en, ram_we, tx_data, tx_start
    );
endinterface

// File: rtl/rs232_ram_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// rs232_ram_cmd_ctrl
//   Command sequencer between the RS-232 packet receiver, a 128x32 RAM and
//   the RS-232 transmitter. Takes one 8-byte packet at a time, checks framing
//   (0x02 ... 0x03) and the XOR checksum over bytes 1..5, performs the encoded
//   RAM write or read, then returns a response packet through a tx_start /
//   tx_done handshake guarded by a timeout.
//
//   Packet layout (byte k = [8k+7:8k]):
//     byte0 = 0x02, byte1 = {we, addr[6:0]}, bytes5..2 = data (byte2 = LSB),
//     byte6 = XOR of bytes 1..5, byte7 = 0x03.
//
// Ports
//   clk_i      : clock, everything on posedge
//   rst_i      : synchronous, active-high reset
//   bus        : master side of rs232_ram_cmd_ctrl_if (packet in, RAM, TX)
//   err_cnt_o  : saturating count of rejected or timed-out packets
//   busy_o     : controller is not idle
// ----------------------------------------------------------------------------
module rs232_ram_cmd_ctrl #(
    parameter bit WR_ACK     = 1'b1,    // 1: writes are acknowledged with a packet
    parameter int TX_TIMEOUT = 150000,  // cycles allowed in TXW before abort
    parameter int TO_W       = 18       // timeout counter width
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rs232_ram_cmd_ctrl_if.master  bus,
    output logic [7:0]            err_cnt_o,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RAM   = 3'd2,
        S_LOAD  = 3'd3,
        S_TXW   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    // Last counter value of the wait window: TXW lasts exactly TX_TIMEOUT cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TX_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [63:0]       pkt_q, pkt_d;
    logic              pkt_ready_q, pkt_ready_d;
    logic [6:0]        ram_addr_q, ram_addr_d;
    logic [31:0]       ram_din_q, ram_din_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [63:0]       tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    // ------------------------------------------------------------------
    // Decode of the latched packet
    // ------------------------------------------------------------------
    logic        accept;
    logic        pkt_we;
    logic [6:0]  pkt_addr;
    logic [31:0] pkt_wdata;
    logic [7:0]  pkt_xor;
    logic        pkt_ok;
    logic        to_hit;
    logic [31:0] resp_data;
    logic [7:0]  resp_chk;

    // pkt_ready_q mirrors state_q==IDLE except in the cycle right after reset.
    assign accept    = bus.pkt_valid & pkt_ready_q;
    assign pkt_we    = pkt_q[15];
    assign pkt_addr  = pkt_q[14:8];
    assign pkt_wdata = pkt_q[47:16];
    assign pkt_xor   = pkt_q[15:8] ^ pkt_q[23:16] ^ pkt_q[31:24]
                     ^ pkt_q[39:32] ^ pkt_q[47:40];
    assign pkt_ok    = (pkt_q[7:0] == 8'h02) && (pkt_q[63:56] == 8'h03)
                     && (pkt_q[55:48] == pkt_xor);
    assign to_hit    = (to_cnt_q == TO_LAST);

    // In LOAD a read's data is on ram_dout (RAM answered the cycle before),
    // so it goes straight into the response without an extra holding register.
    assign resp_data = pkt_we ? pkt_wdata : bus.ram_dout;
    assign resp_chk  = pkt_q[15:8] ^ resp_data[7:0] ^ resp_data[15:8]
                     ^ resp_data[23:16] ^ resp_data[31:24];

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pkt_q       <= '0;
            pkt_ready_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            to_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pkt_q       <= pkt_d;
            pkt_ready_q <= pkt_ready_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            to_cnt_q    <= to_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CHECK;
            S_CHECK: state_d = pkt_ok ? S_RAM : S_ERR;
            S_RAM:   state_d = (pkt_we && !WR_ACK) ? S_IDLE : S_LOAD;
            S_LOAD:  state_d = S_TXW;
            // tx_done wins over a simultaneous timeout.
            S_TXW: begin
                if (bus.tx_done)  state_d = S_IDLE;
                else if (to_hit)  state_d = S_ERR;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        pkt_d       = pkt_q;
        pkt_ready_d = (state_d == S_IDLE);
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_we_d    = ram_we_q;
        ram_en_d    = 1'b0;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        to_cnt_d    = to_cnt_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) pkt_d = bus.pkt_data;
            end
            S_CHECK: begin
                if (pkt_ok) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = pkt_we;
                    ram_addr_d = pkt_addr;
                    ram_din_d  = pkt_wdata;
                end
            end
            S_LOAD: begin
                tx_data_d  = {8'h03, resp_chk, resp_data, pkt_q[15:8], 8'h02};
                tx_start_d = 1'b1;
                to_cnt_d   = '0;
            end
            S_TXW: begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
            S_ERR: begin
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
            default: ;
        endcase
    end

    assign bus.pkt_ready = pkt_ready_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign err_cnt_o     = err_cnt_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_rs232_ram_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rs232_ram_cmd_ctrl
//   Directed + randomized bench. Keeps a word-level model of RAM contents, the
//   expected error count and the last response packet; expected responses are
//   built from the packet format rules. A behavioural RAM answers the DUT.
//   Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_rs232_ram_cmd_ctrl;
    localparam int T = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] err_cnt;
    logic       busy;

    rs232_ram_cmd_ctrl_if bus();

    rs232_ram_cmd_ctrl #(.WR_ACK(1'b1), .TX_TIMEOUT(T), .TO_W(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .err_cnt_o (err_cnt),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    // Environment RAM: synchronous, read data valid the cycle after the strobe.
    logic [31:0] ram [128];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
            else            bus.ram_dout      <= ram[bus.ram_addr];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [128];
    bit          ref_vld [128];
    int          exp_err;
    logic [63:0] exp_tx;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] p;
    logic [31:0] d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_pkt(input bit we, input logic [6:0] a, input logic [31:0] dat);
        logic [7:0] b1;
        b1 = {we, a};
        return {8'h03, b1 ^ dat[7:0] ^ dat[15:8] ^ dat[23:16] ^ dat[31:24], dat, b1, 8'h02};
    endfunction

    function automatic logic [63:0] bad_chk(input logic [63:0] pin);
        logic [63:0] q;
        int i;
        q = pin;
        i = 48 + int'($urandom_range(0, 7));
        q[i] = ~q[i];
        return q;
    endfunction

    function automatic logic [63:0] bad_frame(input logic [63:0] pin);
        logic [63:0] q;
        q = pin;
        if ($urandom_range(0, 1) == 1) q[63:56] = 8'h04;
        else                           q[7:0]   = 8'h02 ^ 8'($urandom_range(1, 255));
        return q;
    endfunction

    // Full transaction with per-cycle checks. ok: packet is well formed.
    task automatic run_pkt(input logic [63:0] pk, input bit ok, input int dly);
        bit          we;
        logic [6:0]  a;
        logic [31:0] dat;
        we  = pk[15];
        a   = pk[14:8];
        dat = pk[47:16];
        chk("rdy_idle", bus.pkt_ready, 1);
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = pk;
        @(negedge clk);
        bus.pkt_valid = 1'b0;
        chk("busy_after_acc", busy, 1);
        chk("rdy_after_acc", bus.pkt_ready, 0);
        @(negedge clk);
        chk("ram_en", bus.ram_en, ok);
        if (ok) begin
            chk("ram_we", bus.ram_we, we);
            chk("ram_addr", bus.ram_addr, a);
            if (we) chk("ram_din", bus.ram_din, dat);
        end
        @(negedge clk);
        chk("ram_en_pulse", bus.ram_en, 0);
        chk("tx_start_early", bus.tx_start, 0);
        if (ok) begin
            if (we) begin
                ref_mem[a] = dat;
                ref_vld[a] = 1'b1;
            end
            exp_tx = mk_pkt(we, a, ref_mem[a]);
        end else begin
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
        @(negedge clk);
        chk("tx_start", bus.tx_start, ok);
        if (ok) begin
            chk("tx_data", bus.tx_data, exp_tx);
            @(negedge clk);
            chk("tx_start_pulse", bus.tx_start, 0);
            chk("busy_txw", busy, 1);
            repeat (dly - 1) @(negedge clk);
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
            chk("busy_done", busy, 0);
            chk("rdy_done", bus.pkt_ready, 1);
        end else begin
            chk("rdy_after_err", bus.pkt_ready, 1);
            chk("busy_after_err", busy, 0);
        end
        chk("err_cnt", err_cnt, exp_err);
        chk("tx_data_hold", bus.tx_data, exp_tx);
    endtask

    // Accept a good packet and stop in the tx_start cycle. With hold set,
    // pkt_valid stays high with pk2 while the controller is busy.
    task automatic start_ok(input logic [63:0] pk, input bit hold, input logic [63:0] pk2);
        chk("rdy_idle_s", bus.pkt_ready, 1);
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = pk;
        @(negedge clk);
        if (hold) bus.pkt_data = pk2;
        else      bus.pkt_valid = 1'b0;
        @(negedge clk);
        chk("ram_en_s", bus.ram_en, 1);
        @(negedge clk);
        @(negedge clk);
        bus.pkt_valid = 1'b0;
        chk("tx_start_s", bus.tx_start, 1);
    endtask

    initial begin
        bus.pkt_valid = 1'b0;
        bus.pkt_data  = '0;
        bus.tx_done   = 1'b0;
        exp_err = 0;
        exp_tx  = '0;
        for (int i = 0; i < 128; i++) ref_vld[i] = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_pkt_ready", bus.pkt_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ram_en", bus.ram_en, 0);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", bus.pkt_ready, 1);

        // Write addr 5 = DEADBEEF, then explicit ack payload
        run_pkt(mk_pkt(1'b1, 7'd5, 32'hDEADBEEF), 1'b1, 2);
        chk("t1_ack_data", bus.tx_data[47:16], 32'hDEADBEEF);
        chk("t1_ack_b1", bus.tx_data[15:8], 8'h85);

        // Write then read addr 127
        run_pkt(mk_pkt(1'b1, 7'd127, 32'h12345678), 1'b1, 1);
        run_pkt(mk_pkt(1'b0, 7'd127, 32'h0), 1'b1, 3);
        chk("t2_resp", bus.tx_data,
            {8'h03, 8'h7F ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12, 32'h12345678, 8'h7F, 8'h02});

        // Checksum off by one bit, bad end byte
        p = mk_pkt(1'b1, 7'd9, 32'hCAFE0001);
        p[48] = ~p[48];
        run_pkt(p, 1'b0, 1);
        chk("t3_err1", err_cnt, 8'd1);
        p = mk_pkt(1'b1, 7'd9, 32'hCAFE0002);
        p[63:56] = 8'h04;
        run_pkt(p, 1'b0, 1);

        // Random mix
        for (int n = 0; n < 40; n++) begin
            logic [6:0] a;
            bit         we;
            int         kind;
            a    = 7'($urandom_range(0, 127));
            we   = !ref_vld[a] || ($urandom_range(0, 1) == 1);
            p    = mk_pkt(we, a, $urandom);
            kind = int'($urandom_range(0, 4));
            if (kind == 0)      run_pkt(bad_chk(p), 1'b0, 1);
            else if (kind == 1) run_pkt(bad_frame(p), 1'b0, 1);
            else                run_pkt(p, 1'b1, int'($urandom_range(1, 4)));
        end

        // pkt_valid while busy is dropped
        run_pkt(mk_pkt(1'b1, 7'd20, 32'hA5A50F0F), 1'b1, 1);
        start_ok(mk_pkt(1'b0, 7'd20, 32'h0), 1'b1, mk_pkt(1'b1, 7'd20, 32'h11112222));
        exp_tx = mk_pkt(1'b0, 7'd20, 32'hA5A50F0F);
        chk("busy_rd_resp", bus.tx_data, exp_tx);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("ignored_ram_en", bus.ram_en, 0);
            chk("ignored_busy", busy, 0);
        end
        run_pkt(mk_pkt(1'b0, 7'd20, $urandom), 1'b1, 2);

        // Saturation
        repeat (256) begin
            p = mk_pkt(1'b0, 7'($urandom_range(0, 127)), $urandom);
            run_pkt(bad_chk(p), 1'b0, 1);
        end
        chk("err_sat", err_cnt, 8'hFF);

        // Reset while waiting for tx_done; the strobed write stays committed
        d = $urandom;
        start_ok(mk_pkt(1'b1, 7'd30, d), 1'b0, '0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdy", bus.pkt_ready, 0);
        chk("mid_rst_tx_start", bus.tx_start, 0);
        chk("mid_rst_tx_data", bus.tx_data, 0);
        chk("mid_rst_ram_en", bus.ram_en, 0);
        chk("mid_rst_err", err_cnt, 0);
        ref_mem[30] = d;
        ref_vld[30] = 1'b1;
        exp_err = 0;
        exp_tx  = '0;
        @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_done_busy", busy, 0);
            chk("late_done_start", bus.tx_start, 0);
        end
        run_pkt(mk_pkt(1'b0, 7'd30, 32'h0), 1'b1, 1);

        // Timeout: tx_start cycle is TXW cycle 1; abort after cycle T
        start_ok(mk_pkt(1'b0, 7'd30, 32'h0), 1'b0, '0);
        for (int k = 2; k <= T; k++) @(negedge clk);
        chk("to_busy_last", busy, 1);
        @(negedge clk);
        chk("to_busy_err", busy, 1);
        chk("to_err_before", err_cnt, exp_err);
        @(negedge clk);
        exp_err = exp_err + 1;
        chk("to_err_after", err_cnt, exp_err);
        chk("to_idle", busy, 0);

        // tx_done on the last allowed cycle is a normal completion
        start_ok(mk_pkt(1'b0, 7'd127, 32'h0), 1'b0, '0);
        for (int k = 2; k <= T; k++) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        chk("bnd_idle", busy, 0);
        chk("bnd_err", err_cnt, exp_err);
        @(negedge clk);
        chk("bnd_err_later", err_cnt, exp_err);
        run_pkt(mk_pkt(1'b1, 7'd0, $urandom), 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
